// File: rtl/mulu_pkg.sv
// mulu_pkg: shared state type, default width and counter sizing for the mulu_seq multiplier.
package mulu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mulu_state_t;
    localparam int MULU_WIDTH = 32;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/mulu_seq_if.sv
// mulu_seq_if: start/busy/done handshake plus operands and product of the sequential multiplier.
interface mulu_seq_if #(parameter int WIDTH = mulu_pkg::MULU_WIDTH);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] c;
    modport master (output start, a, b, input busy, done, c);
    modport slave (input start, a, b, output busy, done, c);
endinterface

// File: rtl/mulu_seq_dp.sv
// mulu_seq_dp: shift-add datapath; load captures operands, step retires one multiplier bit.
module mulu_seq_dp
    import mulu_pkg::*;
#(
    parameter int WIDTH = MULU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULU_EARLY_DONE_EN
    output logic               mplier_zero,
`endif
    output logic [2*WIDTH-1:0] sum
);
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    always_comb begin
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = load ? '0 : step ? sum : acc_q;
        mcand_d  = load ? {{WIDTH{1'b0}}, a} : step ? mcand_q << 1 : mcand_q;
        mplier_d = load ? b : step ? mplier_q >> 1 : mplier_q;
    end

`ifdef MULU_EARLY_DONE_EN
    assign mplier_zero = mplier_q == '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
endmodule

// File: rtl/mulu_seq.sv
// mulu_seq: iterative unsigned multiplier, one bit per clock; MULU_EARLY_DONE_EN finishes
// as soon as the remaining multiplier bits are all zero.
module mulu_seq
    import mulu_pkg::*;
#(
    parameter int WIDTH = MULU_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    mulu_seq_if.slave  bus
);
    localparam int CW = clog2(WIDTH);

    mulu_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] c_q, c_d, sum;
    logic               busy_q, busy_d, done_q, done_d;
    logic               load, step, finish;

`ifdef MULU_EARLY_DONE_EN
    logic mplier_zero;
`endif

    mulu_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .a           (bus.a),
        .b           (bus.b),
`ifdef MULU_EARLY_DONE_EN
        .mplier_zero (mplier_zero),
`endif
        .sum         (sum)
    );

    always_comb begin
        load    = state_q != RUN && bus.start;
        step    = state_q == RUN;
`ifdef MULU_EARLY_DONE_EN
        finish  = mplier_zero;
`else
        finish  = cnt_q == CW'(WIDTH - 1);
`endif
        state_d = step ? (finish ? DONE : RUN) : (load ? RUN : IDLE);
        cnt_d   = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
        // sum already folds in the final partial product, so the product lands on DONE entry
        c_d     = step && finish ? sum : c_q;
        busy_d  = state_d == RUN;
        done_d  = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = c_q;
endmodule

// File: tb/tb_mulu_seq.sv
// tb_mulu_seq: directed self-checking bench for mulu_seq at WIDTH=32.
module tb_mulu_seq;
    localparam int W = 32;
`ifdef MULU_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    mulu_seq_if #(.WIDTH(W)) bus ();
    mulu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic op(input logic [31:0] ia, input logic [31:0] ib, output int cyc, output int bcyc);
        bus.a = ia;
        bus.b = ib;
        bus.start = 1'b1;
        cyc = 0;
        bcyc = 0;
        do begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
            if (bus.busy === 1'b1) bcyc++;
        end while (bus.done !== 1'b1 && cyc < 200);
    endtask

    task automatic run(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [63:0] exp_c, input int exp_run);
        int cyc, bcyc;
        op(ia, ib, cyc, bcyc);
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " c"}, bus.c, exp_c);
        check({tag, " latency"}, 64'(cyc), 64'(exp_run + 1));
        check({tag, " busy"}, 64'(bcyc), 64'(exp_run));
        @(posedge clk); #1;
        check({tag, " pulse"}, 64'(bus.done), 64'd0);
        check({tag, " hold"}, bus.c, exp_c);
    endtask

    initial begin
        int cyc, bcyc, ndone;
        logic [63:0] c_seen;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset c", bus.c, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("9x12", 32'd9, 32'd12, 64'd108, EARLY ? 5 : W);

        // back-to-back: second start issued in the DONE cycle of the first
        op(32'd6, 32'd12, cyc, bcyc);
        check("b2b first done", 64'(bus.done), 64'd1);
        check("b2b first c", bus.c, 64'd72);
        check("b2b first latency", 64'(cyc), 64'(EARLY ? 6 : W + 1));
        run("b2b second", 32'd6, 32'd5, 64'd30, EARLY ? 4 : W);

        run("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, EARLY ? 33 : W);
        run("zero a", 32'd0, 32'hFFFF_FFFF, 64'd0, EARLY ? 33 : W);
        run("zero b", 32'd5, 32'd0, 64'd0, EARLY ? 1 : W);
        run("msb b", 32'd1, 32'h8000_0000, 64'h8000_0000, EARLY ? 33 : W);

        // start pulsed again mid-run with a different a must be ignored
        bus.a = 32'd7;
        bus.b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'd100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 32'd55;
        bus.b = 32'd55;
        ndone = 0;
        c_seen = '1;
        repeat (60) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                ndone++;
                c_seen = bus.c;
            end
        end
        check("ignore start done count", 64'(ndone), 64'd1);
        check("ignore start c", c_seen, 64'd21);
        check("ignore start idle", 64'(bus.busy), 64'd0);

        // async reset mid-run abandons the operation
        bus.a = 32'd9;
        bus.b = 32'd12;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 64'(bus.busy), 64'd0);
        check("mid reset done", 64'(bus.done), 64'd0);
        check("mid reset c", bus.c, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("abandoned no done", 64'(ndone), 64'd0);
        check("abandoned c", bus.c, 64'd0);
        run("after reset", 32'd11, 32'd13, 64'd143, EARLY ? 5 : W);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
